bubble_ctrl: RTL and testbench
==============================

# bubble_ctrl

Pipeline interlock controller for the five-stage MIPS core. It consumes the core's ID-stage register-usage outputs (`exp_read1/2`, `exp_addr1/2`, `tar_addr`) and its `stop` flag. It drives the core's `bbl` input, which freezes PC and IF/ID and injects a bubble into ID/EX. It tracks the destinations of in-flight instructions in a small shift scoreboard, raises `bbl` on any read-after-write hazard, and drains and halts the pipeline after `stop`.

## Interface
Parameters:
- `DEPTH`, 3, number of tracked in-flight stages after ID (EX, MEM, WB).
- `WB_BYPASS`, 1, 1 = regfile forwards the same-cycle WB write to its read ports, so the oldest entry is excluded from comparison.
- `CNT_W`, 32, width of the stall counter.

Ports:
- `clk`  in  1  core clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `exp_read1`  in  1  ID reads source operand 1.
- `exp_addr1`  in  5  source register 1 address.
- `exp_read2`  in  1  ID reads source operand 2.
- `exp_addr2`  in  5  source register 2 address.
- `tar_addr`  in  5  ID destination register; 0 = no write.
- `stop`  in  1  halt instruction is in EX.
- `bbl`  out  1  stall/bubble request to the core; combinational.
- `halted`  out  1  pipeline fully drained after `stop`; registered.
- `stall_cnt`  out  CNT_W  count of hazard stall cycles; registered.

## Operation
- Scoreboard: `sb[0..DEPTH-1]`, 5 bits per entry. `sb[0]` is the EX-stage destination and `sb[DEPTH-1]` is the WB destination. Value 0 means empty or no write.
- Compare window: entries `0 .. DEPTH-1-WB_BYPASS`.
- `hit1` = `exp_read1` && `exp_addr1`≠0 && `exp_addr1` equals any entry in the window. `hit2` is defined the same way for operand 2. `hit = hit1 | hit2`.
- FSM states: RUN, DRAIN, HALT.
  - RUN: `bbl = hit`.
    - Each edge: `sb[0] <= bbl ? 0 : tar_addr`, and `sb[i] <= sb[i-1]`.
    - If `stop`=1: go to DRAIN and load the drain counter with DEPTH. `bbl` is 1 in that same cycle, so the younger ID instruction is not issued.
  - DRAIN: `bbl = 1`; `sb[0] <= 0`; shifting continues; the drain counter decrements each edge. When it reaches 1, go to HALT.
  - HALT: `bbl = 1`; `halted = 1`; scoreboard all zero. HALT is exited only by reset.
- `stop` is ignored in DRAIN and HALT.
- `stall_cnt` increments on each RUN-state edge where `hit`=1. It saturates at all-ones and never wraps. It does not count stop-induced `bbl`.
- Register 0 never creates a hazard, either as a source or as a destination.
- Simultaneous `hit` and `stop` in RUN: `stop` wins the state transition. `stall_cnt` still counts that cycle.

## Timing
- Reset (asynchronous assert, synchronous release):
  - all `sb` = 0, state = RUN, drain counter = 0;
  - `halted` = 0, `stall_cnt` = 0;
  - `bbl` = 0, because the scoreboard is empty.
- `bbl` is a same-cycle combinational function of the inputs and state. It must settle before the core's clock edge. There is no registered path from `exp_*` to `bbl`.
- Dependent back-to-back pair (A writes r, B reads r in the next cycle):
  - WB_BYPASS=1: B stalls DEPTH-1 cycles (2 by default).
  - WB_BYPASS=0: B stalls DEPTH cycles.
- Gap of k independent instructions between A and B: stall = max(0, window − k).
- Stall in progress: the held ID instruction re-presents identical inputs. A bubble (0) enters `sb[0]` each stall cycle, so the hazard clears monotonically.
- `stop` sampled at edge t: `halted` = 1 after edge t+DEPTH. `bbl` = 1 from the cycle `stop` is seen onward.
- Reset asserted mid-DRAIN or mid-stall: immediate return to the reset values above, with no residual `bbl`.

## Test plan
- Reset: drive `rst`=0 while random inputs toggle → `bbl`=0, `halted`=0, `stall_cnt`=0. After release with `exp_read1`=1, `exp_addr1`=5 → `bbl`=0.
- RAW, default parameters: cycle 0 `tar_addr`=3. Cycle 1 `exp_read1`=1, `exp_addr1`=3 held → `bbl`=1 in cycles 1–2 and 0 in cycle 3; `stall_cnt`=2.
- Gap and operand 2: `tar_addr`=7, then one instruction with `tar_addr`=0, then `exp_read2`=1, `exp_addr2`=7 → exactly 1 stall cycle. Repeat with `exp_read2`=0 → 0 stalls.
- r0 and bypass: `tar_addr`=0 followed by a read of r0 → no stall. With WB_BYPASS=0 the RAW case above gives 3 stall cycles.
- Stop drain: `tar_addr`=9, then `stop`=1 for one cycle → `bbl`=1 thereafter; `halted` rises exactly 3 edges later; scoreboard reads zero; a later `stop` pulse has no effect.
- Saturation: CNT_W=4 with a held hazard over 20 stall cycles → `stall_cnt` stops at 15. Async reset mid-DRAIN → `halted`=0, `bbl`=0 without waiting for a clock edge.

Source files
------------

// File: rtl/bubble_ctrl_if.sv
// ---------------------------------------------------------------------------
// bubble_ctrl_if
// ID-stage register-usage bundle between the MIPS core and its interlock
// controller.
//   exp_read1/exp_addr1 : ID reads source operand 1 / its register address
//   exp_read2/exp_addr2 : ID reads source operand 2 / its register address
//   tar_addr            : ID destination register (0 = no write)
//   stop                : halt instruction is in EX
//   bbl                 : stall/bubble request back to the core
// master = core side (drives usage, receives bbl); slave = controller side.
// ---------------------------------------------------------------------------
interface bubble_ctrl_if;
    logic       exp_read1;
    logic [4:0] exp_addr1;
    logic       exp_read2;
    logic [4:0] exp_addr2;
    logic [4:0] tar_addr;
    logic       stop;
    logic       bbl;

    modport master (
        output exp_read1, exp_addr1, exp_read2, exp_addr2, tar_addr, stop,
        input  bbl
    );

    modport slave (
        input  exp_read1, exp_addr1, exp_read2, exp_addr2, tar_addr, stop,
        output bbl
    );
endinterface

// File: rtl/bubble_ctrl.sv
// ---------------------------------------------------------------------------
// bubble_ctrl
// Pipeline interlock controller for the five-stage MIPS core. A shift
// scoreboard holds the destinations of in-flight instructions (EX..WB); any
// ID source read that matches an entry in the compare window raises bbl,
// which freezes PC and IF/ID and injects a bubble into ID/EX. After a stop,
// the pipeline is drained and the controller parks in HALT until reset.
// Ports:
//   clk       : core clock, rising edge
//   rst       : asynchronous active-low reset
//   id        : ID-stage usage bundle (slave modport), bbl is combinational
//   halted    : pipeline fully drained after stop (registered)
//   stall_cnt : saturating count of hazard stall cycles (registered)
// ---------------------------------------------------------------------------
module bubble_ctrl #(
    parameter int DEPTH     = 3,   // tracked stages after ID (EX, MEM, WB)
    parameter int WB_BYPASS = 1,   // 1 = regfile forwards same-cycle WB write
    parameter int CNT_W     = 32
) (
    input  logic              clk,
    input  logic              rst,
    bubble_ctrl_if.slave      id,
    output logic              halted,
    output logic [CNT_W-1:0]  stall_cnt
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        HALT  = 2'd2
    } state_t;

    // With WB bypass the oldest entry is already visible through the regfile,
    // so only the younger entries can cause a hazard.
    localparam int WIN  = DEPTH - WB_BYPASS;
    localparam int DC_W = $clog2(DEPTH + 1);

    state_t          state, state_nxt;
    logic [DC_W-1:0] drain_cnt, drain_nxt;
    logic [4:0]      sb [DEPTH];
    logic [4:0]      sb0_nxt;
    logic            hit1, hit2, hit;
    logic            bbl_int;

    // Hazard detection against the compare window. Register 0 never hazards
    // as a source; an empty entry (0) can then never match a live source.
    always_comb begin
        hit1 = 1'b0;
        hit2 = 1'b0;
        for (int i = 0; i < WIN; i++) begin
            if (sb[i] == id.exp_addr1) hit1 = 1'b1;
            if (sb[i] == id.exp_addr2) hit2 = 1'b1;
        end
        hit1 = hit1 & id.exp_read1 & (id.exp_addr1 != 5'd0);
        hit2 = hit2 & id.exp_read2 & (id.exp_addr2 != 5'd0);
        hit  = hit1 | hit2;
    end

    // Next-state and outputs.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves one
        // unassigned, which would infer a latch.
        state_nxt = state;
        drain_nxt = drain_cnt;
        bbl_int   = 1'b1;
        sb0_nxt   = 5'd0;
        unique case (state)
            RUN: begin
                // stop also blocks the younger ID instruction from issuing.
                bbl_int = hit | id.stop;
                sb0_nxt = bbl_int ? 5'd0 : id.tar_addr;
                if (id.stop) begin
                    state_nxt = DRAIN;
                    drain_nxt = DC_W'(DEPTH);
                end
            end
            DRAIN: begin
                drain_nxt = drain_cnt - DC_W'(1);
                if (drain_cnt == DC_W'(1)) state_nxt = HALT;
            end
            HALT: ;
            default: state_nxt = RUN;
        endcase
    end

    assign id.bbl = bbl_int;
    assign halted = (state == HALT);

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= RUN;
            drain_cnt <= '0;
            stall_cnt <= '0;
            // NOTE: the scoreboard is a few flops, not a RAM, so it is reset;
            // an unreset entry could match a source and stall after reset.
            for (int i = 0; i < DEPTH; i++) sb[i] <= 5'd0;
        end else begin
            state     <= state_nxt;
            drain_cnt <= drain_nxt;
            if (state == HALT) begin
                for (int i = 0; i < DEPTH; i++) sb[i] <= 5'd0;
            end else begin
                sb[0] <= sb0_nxt;
                for (int i = 1; i < DEPTH; i++) sb[i] <= sb[i-1];
            end
            // Only genuine hazards count, and the count saturates.
            if (state == RUN && hit && stall_cnt != '1)
                stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_bubble_ctrl.sv
// ---------------------------------------------------------------------------
// tb_bubble_ctrl
// Self-checking bench for bubble_ctrl. Three instances share one stimulus:
// defaults (a), WB_BYPASS=0 (b), CNT_W=4 (s). A vector table covers RAW,
// gap, operand 2, r0 and stop/drain; hand-written sequences cover reset,
// counter saturation and asynchronous reset mid-DRAIN / in HALT.
// ---------------------------------------------------------------------------
module tb_bubble_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       exp_read1, exp_read2, stop;
    logic [4:0] exp_addr1, exp_addr2, tar_addr;

    logic        halted_a, halted_b, halted_s;
    logic [31:0] cnt_a, cnt_b;
    logic [3:0]  cnt_s;

    int checks = 0;
    int errors = 0;

    bubble_ctrl_if if_a ();
    bubble_ctrl_if if_b ();
    bubble_ctrl_if if_s ();

    assign if_a.exp_read1 = exp_read1;  assign if_b.exp_read1 = exp_read1;  assign if_s.exp_read1 = exp_read1;
    assign if_a.exp_addr1 = exp_addr1;  assign if_b.exp_addr1 = exp_addr1;  assign if_s.exp_addr1 = exp_addr1;
    assign if_a.exp_read2 = exp_read2;  assign if_b.exp_read2 = exp_read2;  assign if_s.exp_read2 = exp_read2;
    assign if_a.exp_addr2 = exp_addr2;  assign if_b.exp_addr2 = exp_addr2;  assign if_s.exp_addr2 = exp_addr2;
    assign if_a.tar_addr  = tar_addr;   assign if_b.tar_addr  = tar_addr;   assign if_s.tar_addr  = tar_addr;
    assign if_a.stop      = stop;       assign if_b.stop      = stop;       assign if_s.stop      = stop;

    bubble_ctrl dut_a (.clk(clk), .rst(rst), .id(if_a), .halted(halted_a), .stall_cnt(cnt_a));
    bubble_ctrl #(.WB_BYPASS(0)) dut_b (.clk(clk), .rst(rst), .id(if_b), .halted(halted_b), .stall_cnt(cnt_b));
    bubble_ctrl #(.CNT_W(4)) dut_s (.clk(clk), .rst(rst), .id(if_s), .halted(halted_s), .stall_cnt(cnt_s));

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    typedef struct {
        logic       rd1;
        logic [4:0] a1;
        logic       rd2;
        logic [4:0] a2;
        logic [4:0] tar;
        logic       stp;
        logic       bbl_a;
        logic       bbl_b;
        logic       hlt;
        int         ca;
        int         cb;
    } vec_t;

    typedef struct {
        int   idx;
        logic bbl_a;
        logic bbl_b;
        logic hlt;
        int   ca;
        int   cb;
    } exp_t;

    vec_t vecs [28];
    exp_t sbq [$];

    function automatic vec_t mk(logic rd1, logic [4:0] a1, logic rd2, logic [4:0] a2,
                                logic [4:0] tar, logic stp, logic ba, logic bb,
                                logic h, int ca, int cb);
        vec_t v;
        v.rd1 = rd1; v.a1 = a1; v.rd2 = rd2; v.a2 = a2; v.tar = tar; v.stp = stp;
        v.bbl_a = ba; v.bbl_b = bb; v.hlt = h; v.ca = ca; v.cb = cb;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic drive(input logic rd1, input logic [4:0] a1, input logic rd2,
                         input logic [4:0] a2, input logic [4:0] tar, input logic stp);
        exp_read1 = rd1; exp_addr1 = a1;
        exp_read2 = rd2; exp_addr2 = a2;
        tar_addr  = tar; stop      = stp;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        exp_t e;
        int   sat;

        // Columns: rd1 a1 rd2 a2 tar stop | bbl_a bbl_b halted cnt_a cnt_b
        vecs[0]  = mk(0, 0, 0, 0, 3, 0,  0, 0, 0, 0, 0);  // A writes r3
        vecs[1]  = mk(1, 3, 0, 0, 0, 0,  1, 1, 0, 0, 0);  // B reads r3, held
        vecs[2]  = mk(1, 3, 0, 0, 0, 0,  1, 1, 0, 1, 1);
        vecs[3]  = mk(1, 3, 0, 0, 0, 0,  0, 1, 0, 2, 2);  // WB entry bypassed in a
        vecs[4]  = mk(1, 3, 0, 0, 0, 0,  0, 0, 0, 2, 3);
        vecs[5]  = mk(0, 0, 0, 0, 7, 0,  0, 0, 0, 2, 3);  // writes r7
        vecs[6]  = mk(0, 0, 0, 0, 0, 0,  0, 0, 0, 2, 3);  // one independent
        vecs[7]  = mk(0, 0, 1, 7, 0, 0,  1, 1, 0, 2, 3);  // operand 2 reads r7
        vecs[8]  = mk(0, 0, 1, 7, 0, 0,  0, 1, 0, 3, 4);
        vecs[9]  = mk(0, 0, 1, 7, 0, 0,  0, 0, 0, 3, 5);
        vecs[10] = mk(0, 0, 0, 0, 7, 0,  0, 0, 0, 3, 5);  // writes r7 again
        vecs[11] = mk(0, 0, 0, 0, 0, 0,  0, 0, 0, 3, 5);
        vecs[12] = mk(0, 0, 0, 7, 0, 0,  0, 0, 0, 3, 5);  // addr 7 but exp_read2=0
        vecs[13] = mk(1, 0, 0, 0, 0, 0,  0, 0, 0, 3, 5);  // reads r0
        vecs[14] = mk(0, 0, 0, 0, 4, 0,  0, 0, 0, 3, 5);
        vecs[15] = mk(0, 0, 0, 0, 5, 0,  0, 0, 0, 3, 5);
        vecs[16] = mk(1, 4, 1, 9, 0, 0,  1, 1, 0, 3, 5);  // r4 in MEM
        vecs[17] = mk(1, 4, 1, 9, 0, 0,  0, 1, 0, 4, 6);
        vecs[18] = mk(0, 0, 1, 5, 0, 0,  0, 1, 0, 4, 7);  // r5 in WB
        vecs[19] = mk(0, 0, 0, 0, 0, 0,  0, 0, 0, 4, 8);
        vecs[20] = mk(0, 0, 0, 0, 9, 0,  0, 0, 0, 4, 8);  // writes r9
        vecs[21] = mk(1, 9, 0, 0, 0, 1,  1, 1, 0, 4, 8);  // hit and stop together
        vecs[22] = mk(1, 9, 0, 0, 0, 0,  1, 1, 0, 5, 9);
        vecs[23] = mk(0, 0, 0, 0, 0, 1,  1, 1, 0, 5, 9);  // stop ignored in DRAIN
        vecs[24] = mk(0, 0, 0, 0, 0, 0,  1, 1, 0, 5, 9);
        vecs[25] = mk(0, 0, 0, 0, 0, 0,  1, 1, 1, 5, 9);  // halted 3 edges after stop
        vecs[26] = mk(0, 0, 0, 0, 0, 1,  1, 1, 1, 5, 9);  // stop ignored in HALT
        vecs[27] = mk(0, 0, 0, 0, 0, 0,  1, 1, 1, 5, 9);

        // ---- reset with toggling inputs ----
        rst = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            drive(1'($urandom), 5'($urandom), 1'($urandom), 5'($urandom), 5'($urandom), 0);
            @(negedge clk);
            check("reset_bbl_a", 32'(if_a.bbl), 0);
            check("reset_bbl_b", 32'(if_b.bbl), 0);
            check("reset_halted", 32'(halted_a), 0);
            check("reset_cnt", cnt_a, 0);
        end
        drive(0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        next_cycle();
        drive(1, 5, 0, 0, 0, 0);
        @(negedge clk);
        check("post_reset_r5_bbl", 32'(if_a.bbl), 0);
        next_cycle();

        // ---- vector table through the scoreboard queue ----
        for (int i = 0; i < 28; i++) begin
            drive(vecs[i].rd1, vecs[i].a1, vecs[i].rd2, vecs[i].a2, vecs[i].tar, vecs[i].stp);
            sbq.push_back('{idx: i, bbl_a: vecs[i].bbl_a, bbl_b: vecs[i].bbl_b,
                            hlt: vecs[i].hlt, ca: vecs[i].ca, cb: vecs[i].cb});
            @(negedge clk);
            if (sbq.size() == 0) begin
                check("vec_queue_empty", 0, 1);
            end else begin
                e = sbq.pop_front();
                sat = (e.ca > 15) ? 15 : e.ca;
                check($sformatf("v%0d_bbl_a", e.idx), 32'(if_a.bbl), 32'(e.bbl_a));
                check($sformatf("v%0d_bbl_b", e.idx), 32'(if_b.bbl), 32'(e.bbl_b));
                check($sformatf("v%0d_bbl_s", e.idx), 32'(if_s.bbl), 32'(e.bbl_a));
                check($sformatf("v%0d_halted_a", e.idx), 32'(halted_a), 32'(e.hlt));
                check($sformatf("v%0d_halted_b", e.idx), 32'(halted_b), 32'(e.hlt));
                check($sformatf("v%0d_cnt_a", e.idx), cnt_a, 32'(e.ca));
                check($sformatf("v%0d_cnt_b", e.idx), cnt_b, 32'(e.cb));
                check($sformatf("v%0d_cnt_s", e.idx), 32'(cnt_s), 32'(sat));
            end
            next_cycle();
        end

        // ---- saturation: repeated r6 hazard, 20 stalls in a, 23 in b ----
        rst = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        check("sat_reset_halted", 32'(halted_a), 0);
        rst = 1'b1;
        next_cycle();
        drive(0, 0, 0, 0, 6, 0);
        next_cycle();
        for (int k = 1; k <= 30; k++) begin
            drive(1, 6, 0, 0, 6, 0);
            @(negedge clk);
            check($sformatf("sat_bbl_a_k%0d", k), 32'(if_a.bbl), 32'((k % 3) != 0));
            check($sformatf("sat_bbl_b_k%0d", k), 32'(if_b.bbl), 32'((k % 4) != 0));
            check($sformatf("sat_bbl_s_k%0d", k), 32'(if_s.bbl), 32'((k % 3) != 0));
            next_cycle();
        end
        drive(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        check("sat_cnt_a", cnt_a, 20);
        check("sat_cnt_b", cnt_b, 23);
        check("sat_cnt_s", 32'(cnt_s), 15);
        next_cycle();

        // ---- async reset mid-DRAIN ----
        drive(0, 0, 0, 0, 9, 0);
        next_cycle();
        drive(0, 0, 0, 0, 0, 1);
        @(negedge clk);
        check("drain_stop_bbl", 32'(if_a.bbl), 1);
        next_cycle();
        drive(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        check("drain_bbl", 32'(if_a.bbl), 1);
        check("drain_halted", 32'(halted_a), 0);
        #1 rst = 1'b0;
        #1;
        check("drain_rst_bbl", 32'(if_a.bbl), 0);
        check("drain_rst_halted", 32'(halted_a), 0);
        check("drain_rst_cnt", cnt_a, 0);
        @(negedge clk);
        rst = 1'b1;
        next_cycle();

        // ---- async reset in HALT ----
        drive(0, 0, 0, 0, 0, 1);
        next_cycle();
        drive(0, 0, 0, 0, 0, 0);
        next_cycle();
        next_cycle();
        next_cycle();
        @(negedge clk);
        check("halt_halted", 32'(halted_a), 1);
        check("halt_bbl", 32'(if_a.bbl), 1);
        #1 rst = 1'b0;
        #1;
        check("halt_rst_halted", 32'(halted_a), 0);
        check("halt_rst_bbl", 32'(if_a.bbl), 0);
        @(negedge clk);
        rst = 1'b1;
        next_cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
